sample_fifo_unit: RTL and testbench

SAMPLE_FIFO_UNIT -- requirements
Module: sample_fifo_unit

---
 rtl/sample_fifo_unit.sv | 90 +++++++++
 tb/tb_sample_fifo_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo_unit.sv
// Stereo sample FIFO feeding the I2S unit: buffers {left,right} 24-bit pairs
// and hands one pair out per request, emitting silence and counting underruns when empty.
module sample_fifo_unit #(
    parameter int DEPTH  = 16,
    parameter int UCNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       play_in,
    input  logic                       wr_valid_in,
    output logic                       wr_ready_out,
    input  logic [23:0]                audio0_in,
    input  logic [23:0]                audio1_in,
    input  logic                       req_in,
    output logic [23:0]                audio0_out,
    output logic [23:0]                audio1_out,
    output logic                       tick_out,
    output logic [$clog2(DEPTH):0]     level_out,
    output logic                       underrun_out,
    output logic [UCNT_W-1:0]          underrun_count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [47:0]      mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] level;
    logic             push;
    logic             pop;
    logic             starve;

    // A pop during the same cycle never frees space for a push; readiness looks only at level.
    assign wr_ready_out = play_in && !rst && (level < LVL_W'(DEPTH));
    assign push         = wr_valid_in && wr_ready_out;
    assign pop          = req_in && play_in && (level != '0);
    assign starve       = req_in && play_in && (level == '0);
    assign level_out    = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {audio0_in, audio1_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr               <= '0;
            rptr               <= '0;
            level              <= '0;
            audio0_out         <= '0;
            audio1_out         <= '0;
            tick_out           <= 1'b0;
            underrun_out       <= 1'b0;
            underrun_count_out <= '0;
        end else if (!play_in) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            audio0_out   <= '0;
            audio1_out   <= '0;
            tick_out     <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            tick_out     <= req_in;
            underrun_out <= starve;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                audio0_out <= mem[rptr][47:24];
                audio1_out <= mem[rptr][23:0];
                rptr       <= rptr + 1'b1;
            end else if (starve) begin
                audio0_out <= '0;
                audio1_out <= '0;
                if (underrun_count_out != '1) begin
                    underrun_count_out <= underrun_count_out + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_fifo_unit.sv
// Self-checking bench for sample_fifo_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_sample_fifo_unit;

    localparam int DEPTH  = 16;
    localparam int UCNT_W = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int UMAX   = (1 << UCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              play_in;
    logic              wr_valid_in;
    logic              wr_ready_out;
    logic [23:0]       audio0_in;
    logic [23:0]       audio1_in;
    logic              req_in;
    logic [23:0]       audio0_out;
    logic [23:0]       audio1_out;
    logic              tick_out;
    logic [LVL_W-1:0]  level_out;
    logic              underrun_out;
    logic [UCNT_W-1:0] underrun_count_out;

    always #5 clk = ~clk;

    sample_fifo_unit #(.DEPTH(DEPTH), .UCNT_W(UCNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .play_in            (play_in),
        .wr_valid_in        (wr_valid_in),
        .wr_ready_out       (wr_ready_out),
        .audio0_in          (audio0_in),
        .audio1_in          (audio1_in),
        .req_in             (req_in),
        .audio0_out         (audio0_out),
        .audio1_out         (audio1_out),
        .tick_out           (tick_out),
        .level_out          (level_out),
        .underrun_out       (underrun_out),
        .underrun_count_out (underrun_count_out)
    );

    // Reference model: a plain queue of stored pairs plus the expected output registers.
    logic [47:0] model_q[$];
    logic [23:0] m_a0;
    logic [23:0] m_a1;
    bit          m_tick;
    bit          m_und;
    int          m_cnt;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, predict, then check after the next rising edge.
    task automatic applyStimulus(input bit r, input bit p, input bit v,
                                 input logic [23:0] d0, input logic [23:0] d1, input bit rq);
        bit          ready;
        logic [47:0] e;
        rst = r; play_in = p; wr_valid_in = v; audio0_in = d0; audio1_in = d1; req_in = rq;
        #1;
        ready = !r && p && (model_q.size() < DEPTH);
        checkOutput("wr_ready", 64'(wr_ready_out), 64'(ready));
        if (r) begin
            model_q.delete();
            m_a0 = '0; m_a1 = '0; m_tick = 0; m_und = 0; m_cnt = 0;
        end else if (!p) begin
            model_q.delete();
            m_a0 = '0; m_a1 = '0; m_tick = 0; m_und = 0;
        end else begin
            m_tick = rq;
            m_und  = 0;
            if (rq) begin
                if (model_q.size() > 0) begin
                    e = model_q.pop_front();
                    m_a0 = e[47:24];
                    m_a1 = e[23:0];
                end else begin
                    m_a0 = '0; m_a1 = '0; m_und = 1;
                    if (m_cnt < UMAX) m_cnt++;
                end
            end
            if (v && ready) model_q.push_back({d0, d1});
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("audio0", 64'(audio0_out), 64'(m_a0));
        checkOutput("audio1", 64'(audio1_out), 64'(m_a1));
        checkOutput("tick", 64'(tick_out), 64'(m_tick));
        checkOutput("underrun", 64'(underrun_out), 64'(m_und));
        checkOutput("ucount", 64'(underrun_count_out), 64'(m_cnt));
        checkOutput("level", 64'(level_out), 64'(model_q.size()));
    endtask

    task automatic idleCycle();
        applyStimulus(0, 1, 0, 24'h0, 24'h0, 0);
    endtask

    task automatic pushSample(input logic [23:0] d0, input logic [23:0] d1);
        applyStimulus(0, 1, 1, d0, d1, 0);
    endtask

    task automatic requestSample();
        applyStimulus(0, 1, 0, 24'h0, 24'h0, 1);
    endtask

    logic [23:0] pushed0 [DEPTH+1];
    logic [23:0] pushed1 [DEPTH+1];
    int          pv;
    int          pr;
    bit          last_req;
    bit          rq;

    initial begin
        rst = 1; play_in = 0; wr_valid_in = 0; audio0_in = '0; audio1_in = '0; req_in = 0;
        model_q.delete();
        m_a0 = '0; m_a1 = '0; m_tick = 0; m_und = 0; m_cnt = 0;
        @(negedge clk);
        applyStimulus(1, 1, 1, 24'h123456, 24'h654321, 1);
        applyStimulus(1, 0, 0, 24'h0, 24'h0, 0);
        checkOutput("reset_level", 64'(level_out), 64'd0);

        // Single push then pop.
        pushSample(24'h000001, 24'hFFFFFF);
        requestSample();
        checkOutput("s1_audio0", 64'(audio0_out), 64'h000001);
        checkOutput("s1_audio1", 64'(audio1_out), 64'hFFFFFF);

        // Fill past full; the extra push is refused and order is preserved.
        for (int i = 0; i < DEPTH + 1; i++) begin
            pushed0[i] = 24'($urandom);
            pushed1[i] = 24'($urandom);
            pushSample(pushed0[i], pushed1[i]);
        end
        checkOutput("full_level", 64'(level_out), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            requestSample();
            checkOutput("order_a0", 64'(audio0_out), 64'(pushed0[i]));
            checkOutput("order_a1", 64'(audio1_out), 64'(pushed1[i]));
        end

        // Underruns up to saturation; standby keeps the count.
        for (int i = 0; i < 3; i++) begin
            requestSample();
            idleCycle();
        end
        checkOutput("und3", 64'(underrun_count_out), 64'd3);
        applyStimulus(0, 0, 0, 24'h0, 24'h0, 1);
        checkOutput("und_standby", 64'(underrun_count_out), 64'd3);
        for (int i = 0; i < UMAX + 2; i++) begin
            requestSample();
            idleCycle();
        end
        checkOutput("und_sat", 64'(underrun_count_out), 64'(UMAX));

        // Simultaneous push and pop at level 5, plus push with req at level 0.
        applyStimulus(0, 0, 0, 24'h0, 24'h0, 0);
        applyStimulus(0, 1, 1, 24'hA00000, 24'hB00000, 1);
        checkOutput("bypass_level", 64'(level_out), 64'd1);
        for (int i = 1; i < 5; i++) pushSample(24'(i), 24'(i + 100));
        applyStimulus(0, 1, 1, 24'h777777, 24'h888888, 1);
        checkOutput("pp_level", 64'(level_out), 64'd5);
        checkOutput("pp_oldest", 64'(audio0_out), 64'hA00000);

        // Standby flush at level 8, then reset mid-stream at level 6.
        while (model_q.size() < 8) pushSample(24'($urandom), 24'($urandom));
        applyStimulus(0, 0, 0, 24'h0, 24'h0, 0);
        checkOutput("flush_level", 64'(level_out), 64'd0);
        requestSample();
        checkOutput("flush_und", 64'(underrun_out), 64'd1);
        for (int i = 0; i < 6; i++) pushSample(24'($urandom), 24'($urandom));
        requestSample();
        pushSample(24'h1, 24'h2);
        applyStimulus(1, 1, 0, 24'h0, 24'h0, 0);
        checkOutput("rst_level", 64'(level_out), 64'd0);
        idleCycle();

        // Randomized traffic in phases with varying push/request density.
        last_req = 0;
        for (int ph = 0; ph < 20; ph++) begin
            pv = $urandom_range(10, 95);
            pr = $urandom_range(5, 60);
            for (int i = 0; i < 100; i++) begin
                rq = !last_req && ($urandom_range(0, 99) < pr);
                last_req = rq;
                applyStimulus($urandom_range(0, 199) == 0,
                              $urandom_range(0, 59) != 0,
                              $urandom_range(0, 99) < pv,
                              24'($urandom), 24'($urandom), rq);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
